// File: rtl/answer_picker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : answer_picker_pkg
// Description : Register offsets, register bit positions and FSM state
//               encoding shared by the answer picker and its remainder engine.
// Revision    : 1.0 - initial release
// ============================================================================
package answer_picker_pkg;

    // Word offsets decoded from addr[3:2]
    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_RESULT = 2'd2;
    localparam logic [1:0] c_REG_NUM    = 2'd3;

    // CTRL bit positions
    localparam int c_CTRL_START_BIT  = 0;
    localparam int c_CTRL_IRQ_EN_BIT = 1;

    // STATUS bit positions
    localparam int c_STATUS_BUSY_BIT   = 0;
    localparam int c_STATUS_DONE_BIT   = 1;
    localparam int c_STATUS_IRQ_EN_BIT = 2;

    // Remainder engine states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/seq_mod_reducer.sv
`default_nettype none
// ============================================================================
// Module      : seq_mod_reducer
// Description : Bit-serial restoring remainder engine. Captures a snapshot and
//               a modulus on start, then processes one snapshot bit per cycle,
//               MSB first. done is high during the final step, and remainder
//               carries the finished result in that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mod_reducer
    import answer_picker_pkg::*;
#(
    parameter int PRNG_WIDTH = 32,
    parameter int MOD_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start,
    input  logic [PRNG_WIDTH-1:0] snapshot,
    input  logic [MOD_WIDTH-1:0]  count,
    output logic                  busy,
    output logic                  done,
    output logic [MOD_WIDTH-1:0]  remainder
);

    localparam int c_CNT_W = $clog2(PRNG_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRNG_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_e                r_state;
    state_e                w_state_next;
    logic [PRNG_WIDTH-1:0] r_snap;
    logic [MOD_WIDTH-1:0]  r_count;
    logic [MOD_WIDTH-1:0]  r_rem;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [MOD_WIDTH:0]    w_shift;
    logic [MOD_WIDTH:0]    w_rem_next;
    logic                  w_last;
    logic                  w_unused_msb;

    assign busy      = (r_state == ST_CALC);
    assign w_last    = busy && (r_cnt == '0);
    assign done      = w_last;
    assign remainder = w_rem_next[MOD_WIDTH-1:0];
    // The stored remainder is always below count, so the reduced MSB is zero
    assign w_unused_msb = w_rem_next[MOD_WIDTH];

    // One restoring step: shift in the next snapshot bit, subtract if it fits
    always_comb begin
        w_shift    = {r_rem, r_snap[r_cnt]};
        w_rem_next = w_shift;
        if (w_shift >= {1'b0, r_count}) begin
            w_rem_next = w_shift - {1'b0, r_count};
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_CALC;
            ST_CALC: if (w_last) w_state_next = ST_IDLE;
            default:             w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: load operands on start, then one bit per CALC cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_snap  <= '0;
            r_count <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_snap  <= snapshot;
                r_count <= count;
                r_rem   <= '0;
                r_cnt   <= c_CNT_LAST;
            end
        end else begin
            r_rem <= w_rem_next[MOD_WIDTH-1:0];
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/answer_picker.sv
`default_nettype none
// ============================================================================
// Module      : answer_picker
// Description : OBI slave that snapshots the PRNG output on command and reduces
//               it modulo a programmable answer count. Exposes the index via a
//               register, a one-cycle valid strobe and a level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module answer_picker
    import answer_picker_pkg::*;
#(
    parameter int PRNG_WIDTH     = 32,
    parameter int MOD_WIDTH      = 8,
    parameter int NUM_ANSWERS    = 20,
    parameter int ADDR_WIDTH_OBI = 32,
    parameter int DATA_WIDTH_OBI = 32,
    parameter int ID_WIDTH_OBI   = 1     // set from SbrObiCfg.IdWidth by the integrator
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [ADDR_WIDTH_OBI-1:0] addr_i,
    input  logic [DATA_WIDTH_OBI-1:0] wdata_i,
    input  logic [ID_WIDTH_OBI-1:0]   aid_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH_OBI-1:0] rdata_o,
    output logic [ID_WIDTH_OBI-1:0]   rid_o,
    output logic                      err_o,
    input  logic [PRNG_WIDTH-1:0]     prn_i,
    output logic [MOD_WIDTH-1:0]      answer_idx_o,
    output logic                      answer_valid_o,
    output logic                      irq_o
);

    localparam logic [MOD_WIDTH-1:0] c_NUM_RESET = MOD_WIDTH'(NUM_ANSWERS);

    logic [1:0]                w_addr;
    logic                      w_busy;
    logic                      w_calc_done;
    logic [MOD_WIDTH-1:0]      w_remainder;
    logic                      w_err;
    logic                      w_start;
    logic                      w_ctrl_wr;
    logic                      w_num_wr;
    logic                      w_result_rd;
    logic [DATA_WIDTH_OBI-1:0] w_rdata;
    logic                      w_unused;

    logic                      r_rvalid;
    logic [ID_WIDTH_OBI-1:0]   r_rid;
    logic                      r_err;
    logic [DATA_WIDTH_OBI-1:0] r_rdata;
    logic [MOD_WIDTH-1:0]      r_num;
    logic                      r_irq_en;
    logic                      r_done;
    logic [MOD_WIDTH-1:0]      r_result;
    logic                      r_valid;

    assign w_addr = addr_i[3:2];
    // Byte enables and undecoded address/data bits carry no meaning here
    assign w_unused = ^{be_i, addr_i[ADDR_WIDTH_OBI-1:4], addr_i[1:0],
                        wdata_i[DATA_WIDTH_OBI-1:MOD_WIDTH]};

    assign gnt_o          = req_i;
    assign rvalid_o       = r_rvalid;
    assign rid_o          = r_rid;
    assign err_o          = r_err;
    assign rdata_o        = r_rdata;
    assign answer_idx_o   = r_result;
    assign answer_valid_o = r_valid;
    assign irq_o          = r_done & r_irq_en;

    assign w_start     = req_i && we_i && (w_addr == c_REG_CTRL) &&
                         wdata_i[c_CTRL_START_BIT] && !w_busy;
    assign w_ctrl_wr   = req_i && we_i && (w_addr == c_REG_CTRL) && !w_err;
    assign w_num_wr    = req_i && we_i && (w_addr == c_REG_NUM) && !w_err;
    assign w_result_rd = req_i && !we_i && (w_addr == c_REG_RESULT);

    // Access legality: errored accesses leave all state untouched
    always_comb begin
        w_err = 1'b0;
        case (w_addr)
            c_REG_CTRL:   w_err = !we_i || (wdata_i[c_CTRL_START_BIT] && w_busy);
            c_REG_STATUS: w_err = we_i;
            c_REG_RESULT: w_err = we_i;
            c_REG_NUM:    w_err = we_i && ((wdata_i[MOD_WIDTH-1:0] == '0) || w_busy);
            default:      w_err = 1'b0;
        endcase
    end

    // Read data mux
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            c_REG_STATUS: begin
                w_rdata[c_STATUS_BUSY_BIT]   = w_busy;
                w_rdata[c_STATUS_DONE_BIT]   = r_done;
                w_rdata[c_STATUS_IRQ_EN_BIT] = r_irq_en;
            end
            c_REG_RESULT: w_rdata[MOD_WIDTH-1:0] = r_result;
            c_REG_NUM:    w_rdata[MOD_WIDTH-1:0] = r_num;
            default:      w_rdata = '0;
        endcase
    end

    // OBI response phase, one cycle after the accept
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= req_i;
            if (req_i) begin
                r_rid   <= aid_i;
                r_err   <= w_err;
                r_rdata <= (!we_i && !w_err) ? w_rdata : '0;
            end
        end
    end

    // Software-visible registers; a completion outranks a same-cycle RESULT read
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_num    <= c_NUM_RESET;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_calc_done;
            if (w_ctrl_wr) r_irq_en <= wdata_i[c_CTRL_IRQ_EN_BIT];
            if (w_num_wr)  r_num    <= wdata_i[MOD_WIDTH-1:0];
            if (w_calc_done) begin
                r_result <= w_remainder;
                r_done   <= 1'b1;
            end else if (w_start || w_result_rd) begin
                r_done <= 1'b0;
            end
        end
    end

    seq_mod_reducer #(
        .PRNG_WIDTH (PRNG_WIDTH),
        .MOD_WIDTH  (MOD_WIDTH)
    ) u_reducer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start     (w_start),
        .snapshot  (prn_i),
        .count     (r_num),
        .busy      (w_busy),
        .done      (w_calc_done),
        .remainder (w_remainder)
    );

endmodule
`default_nettype wire

// File: tb/tb_answer_picker.sv
`default_nettype none
// ============================================================================
// Module      : tb_answer_picker
// Description : Directed and randomized self-checking bench for answer_picker.
//               Expected indices come from plain modulo arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_answer_picker;

    localparam int PW = 32;
    localparam int MW = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    localparam logic [1:0] CTRL   = 2'd0;
    localparam logic [1:0] STATUS = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;
    localparam logic [1:0] NUM    = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    be = 4'hF;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [IW-1:0] aid = '0;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic          err;
    logic [PW-1:0] prn = '0;
    logic [MW-1:0] idx;
    logic          valid;
    logic          irq;

    int total = 0;
    int bad = 0;

    // Reference state
    logic [MW-1:0] m_num;
    logic [MW-1:0] m_result;

    always #5 clk = ~clk;

    answer_picker #(
        .PRNG_WIDTH     (PW),
        .MOD_WIDTH      (MW),
        .NUM_ANSWERS    (20),
        .ADDR_WIDTH_OBI (AW),
        .DATA_WIDTH_OBI (DW),
        .ID_WIDTH_OBI   (IW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .we_i           (we),
        .be_i           (be),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .aid_i          (aid),
        .gnt_o          (gnt),
        .rvalid_o       (rvalid),
        .rdata_o        (rdata),
        .rid_o          (rid),
        .err_o          (err),
        .prn_i          (prn),
        .answer_idx_o   (idx),
        .answer_valid_o (valid),
        .irq_o          (irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One OBI access; called just after a rising edge, returns one cycle later
    task automatic obi(input logic w, input logic [1:0] sel, input logic [DW-1:0] wd,
                       output logic [DW-1:0] rd, output logic er);
        logic [IW-1:0] id;
        id    = IW'($urandom);
        req   = 1'b1;
        we    = w;
        addr  = {28'($urandom), sel, 2'($urandom)};
        wdata = wd;
        aid   = id;
        be    = 4'($urandom);
        #1;
        chk("gnt", gnt, 1'b1);
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
        chk("rvalid", rvalid, 1'b1);
        chk("rid", rid, id);
        rd = rdata;
        er = err;
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] sel, input logic [DW-1:0] exp);
        logic [DW-1:0] rd;
        logic er;
        obi(1'b0, sel, '0, rd, er);
        chk({tag, "_err"}, er, 1'b0);
        chk(tag, rd, exp);
    endtask

    task automatic acc_err(input string tag, input logic w, input logic [1:0] sel,
                           input logic [DW-1:0] wd, input logic exp_err);
        logic [DW-1:0] rd;
        logic er;
        obi(w, sel, wd, rd, er);
        chk({tag, "_err"}, er, exp_err);
        chk({tag, "_rdata"}, rd, '0);
    endtask

    // Waits (bounded) for the valid strobe and checks latency, index and pulse width
    task automatic wait_valid(input string tag, input int exp_lat, input logic [MW-1:0] exp_idx);
        int lat;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            if (valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_idx"}, idx, exp_idx);
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, valid, 1'b0);
        chk({tag, "_idx_hold"}, idx, exp_idx);
    endtask

    initial begin
        logic [PW-1:0] p;
        logic [MW-1:0] n;
        logic [MW-1:0] old;
        int pulses;

        m_num    = 8'd20;
        m_result = '0;

        // 1. reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idx", idx, '0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_reg("rst_num", NUM, 32'd20);
        rd_reg("rst_status", STATUS, 32'd0);
        @(posedge clk);
        #1;
        chk("rvalid_drop", rvalid, 1'b0);

        // 2. DEADBEEF mod 20, busy tracked with back-to-back STATUS reads
        prn = 32'hDEADBEEF;
        acc_err("start1", 1'b1, CTRL, 32'h1, 1'b0);
        prn = $urandom;
        m_result = MW'(32'hDEADBEEF % 32'd20);
        chk("calc1_valid_t1", valid, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            rd_reg("calc1_status", STATUS, (k <= 32) ? 32'd1 : 32'd2);
            chk("calc1_valid", valid, (k + 1 == 33) ? 1'b1 : 1'b0);
            if (k + 1 == 33) chk("calc1_idx", idx, m_result);
        end
        rd_reg("calc1_result", RESULT, 32'(m_result));
        rd_reg("calc1_status_after", STATUS, 32'd0);

        // 3. NUM=7 and NUM=1
        acc_err("num7", 1'b1, NUM, 32'd7, 1'b0);
        m_num = 8'd7;
        prn = 32'hDEADBEEF;
        acc_err("start7", 1'b1, CTRL, 32'h1, 1'b0);
        m_result = MW'(32'hDEADBEEF % 32'(m_num));
        wait_valid("mod7", 32, m_result);
        rd_reg("mod7_result", RESULT, 32'(m_result));
        acc_err("num1", 1'b1, NUM, 32'd1, 1'b0);
        m_num = 8'd1;
        acc_err("start1b", 1'b1, CTRL, 32'h1, 1'b0);
        m_result = '0;
        wait_valid("mod1", 32, m_result);
        rd_reg("mod1_result", RESULT, 32'd0);

        // 4. interrupt path
        acc_err("num20", 1'b1, NUM, 32'd20, 1'b0);
        m_num = 8'd20;
        prn = 32'hDEADBEEF;
        acc_err("start_irq", 1'b1, CTRL, 32'h3, 1'b0);
        m_result = MW'(32'hDEADBEEF % 32'd20);
        chk("irq_low_busy", irq, 1'b0);
        wait_valid("irq_calc", 32, m_result);
        chk("irq_high", irq, 1'b1);
        rd_reg("irq_status", STATUS, 32'd6);
        chk("irq_still_high", irq, 1'b1);
        rd_reg("irq_result", RESULT, 32'(m_result));
        chk("irq_fall", irq, 1'b0);
        rd_reg("irq_status2", STATUS, 32'd4);

        // 5. accesses during CALC
        acc_err("ctrl_irq_off", 1'b1, CTRL, 32'h0, 1'b0);
        prn = 32'h0BADF00D;
        acc_err("start5", 1'b1, CTRL, 32'h1, 1'b0);
        prn = $urandom;
        old = MW'(32'h0BADF00D % 32'd20);
        acc_err("restart_busy", 1'b1, CTRL, 32'h1, 1'b1);
        acc_err("restart_irq_busy", 1'b1, CTRL, 32'h3, 1'b1);
        rd_reg("busy_status", STATUS, 32'd1);
        acc_err("num_busy", 1'b1, NUM, 32'd5, 1'b1);
        rd_reg("num_unchanged", NUM, 32'd20);
        wait_valid("calc5", 27, old);
        m_result = old;
        rd_reg("calc5_result", RESULT, 32'(m_result));
        rd_reg("calc5_status", STATUS, 32'd0);
        acc_err("num0", 1'b1, NUM, 32'd0, 1'b1);
        rd_reg("num0_unchanged", NUM, 32'd20);

        // 6. illegal accesses
        acc_err("rd_ctrl", 1'b0, CTRL, 32'h0, 1'b1);
        acc_err("wr_status", 1'b1, STATUS, 32'h7, 1'b1);
        acc_err("wr_result", 1'b1, RESULT, 32'h5, 1'b1);
        rd_reg("result_unchanged", RESULT, 32'(m_result));

        // done set in the cycle of a RESULT read: set wins
        prn = 32'h12345678;
        acc_err("start_race", 1'b1, CTRL, 32'h1, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        rd_reg("race_old_result", RESULT, 32'(m_result));
        m_result = MW'(32'h12345678 % 32'd20);
        chk("race_valid", valid, 1'b1);
        chk("race_idx", idx, m_result);
        rd_reg("race_status", STATUS, 32'd2);
        rd_reg("race_result", RESULT, 32'(m_result));

        // randomized counts against plain modulo, including both extremes
        for (int i = 0; i < 10; i++) begin
            n = (i == 0) ? 8'd1 : (i == 1) ? 8'd255 : MW'($urandom_range(1, 255));
            p = $urandom;
            acc_err("rnd_num", 1'b1, NUM, {$urandom, n} >> 0 & 32'h000000FF | 32'(n), 1'b0);
            m_num = n;
            prn = p;
            acc_err("rnd_start", 1'b1, CTRL, 32'h1, 1'b0);
            prn = $urandom;
            m_result = MW'(p % 32'(m_num));
            wait_valid("rnd", 32, m_result);
            rd_reg("rnd_result", RESULT, 32'(m_result));
        end

        // reset in the middle of a calculation
        chk("pre_reset_idx_nonzero", (idx != '0), 1'b1);
        prn = 32'hFFFFFFFF;
        acc_err("start_rst", 1'b1, CTRL, 32'h3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_idx", idx, '0);
        chk("rst_mid_valid", valid, 1'b0);
        chk("rst_mid_irq", irq, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid) pulses++;
            @(posedge clk);
            #1;
        end
        chk("rst_no_pulse", pulses, 0);
        rd_reg("rst_mid_status", STATUS, 32'd0);
        rd_reg("rst_mid_num", NUM, 32'd20);
        rd_reg("rst_mid_result", RESULT, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
